// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundles the per-core request bus and the data-memory port of the DM arbiter.
//
// Signals (core-side, packed per core):
//   req/we        per-core request and write flag
//   addr/wdata    packed address / write data, core i at [i*W +: W]
//   ack           one-cycle completion pulse for the served core
//   rdata         read data, valid in the ack cycle and held until the next read completes
//   grant_id      index of the core currently or last served
//   busy          arbiter not idle
// Signals (memory-side):
//   mem_addr/mem_we/mem_wdata  DM request, driven only by the arbiter
//   mem_rdata                  DM read data
//
// Modports: slave = the arbiter, master = the cores plus the DM instance.
interface dm_arbiter_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 16
);
    localparam int unsigned IdW = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        we;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata;
    logic [NUM_CORES-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [IdW-1:0]              grant_id;
    logic                        busy;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_we;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ack, rdata, grant_id, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ack, rdata, grant_id, busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data memory between NUM_CORES cores.
//
// One requester is picked per arbitration (round-robin from the last served core), its
// request is latched, the DM access is sequenced (IDLE -> ISSUE -> [WAIT] -> DONE) and a
// one-cycle ack is returned. All outputs are registered.
//
// Ports:
//   clk_i   system clock, posedge
//   rst_ni  asynchronous active-low reset
//   bus     dm_arbiter_if.slave (core request bus + DM port)
//
// Build option: define DM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority
// (lowest eligible index wins). The one-cycle mask on the just-served core stays active.
module dm_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    dm_arbiter_if.slave bus
);
    localparam int unsigned IdW  = $clog2(NUM_CORES);
    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [IdW-1:0]       last_q, last_d;
    logic                 mask_q, mask_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

    logic [NUM_CORES-1:0] elig;
    logic                 found;
    logic [IdW-1:0]       win;
    logic [IdW-1:0]       idx;

    // The core served last is excluded for one IDLE cycle, covering the cycle in which it
    // drops req in response to ack.
    always_comb begin
        elig = bus.req;
        if (mask_q) begin
            elig[last_q] = 1'b0;
        end
    end

    // Iterate from the lowest to the highest priority so the last hit is the winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
`ifdef DM_ARB_FIXED_PRIO_EN
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx = IdW'(i);
            if (elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`else
        // Search order is last+1, last+2, ..., last (+NUM_CORES truncates to +0).
        for (int i = NUM_CORES; i >= 1; i--) begin
            idx = last_q + IdW'(i);
            if (elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                mask_d = 1'b0;
                if (found) begin
                    grant_d     = win;
                    mem_addr_d  = bus.addr[ADDR_W*int'(win) +: ADDR_W];
                    mem_wdata_d = bus.wdata[DATA_W*int'(win) +: DATA_W];
                    mem_we_d    = bus.we[win];
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // mem_we_q holds the latched write flag for exactly this cycle.
                if (mem_we_q) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = StDone;
                end else begin
                    cnt_d   = CntW'(MEM_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rdata_d        = bus.mem_rdata;
                    ack_d[grant_q] = 1'b1;
                    state_d        = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                last_d  = grant_q;
                mask_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= IdW'(NUM_CORES - 1);
            mask_q      <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (DM) between NUM_CORES processor cores in the multi-core build.
- Each core's control unit asks for a DM read or write through a request/acknowledge handshake. The arbiter picks one requester, sequences the memory access and returns read data with a one-cycle acknowledge.
- Sits between the per-core bus/control logic and the DM instance. Only the arbiter drives the DM ports.

Parameters:
- NUM_CORES, 4: number of requesting cores; power of two, >= 2.
- ADDR_W, 8: DM address width.
- DATA_W, 16: DM data width; matches the core bus width.
- MEM_LAT, 1: DM read latency in cycles, >= 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CORES  per-core request; held high until the matching ack.
- we  in  NUM_CORES  per-core write flag (1 = write, 0 = read); valid while req is high.
- addr  in  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CORES*DATA_W  packed write data; core i at [i*DATA_W +: DATA_W].
- ack  out  NUM_CORES  one-cycle completion pulse for the served core.
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read completes.
- grant_id  out  $clog2(NUM_CORES)  index of the core currently or last served.
- busy  out  1  high whenever the FSM is not in IDLE.
- mem_addr  out  ADDR_W  DM address.
- mem_we  out  1  DM write strobe.
- mem_wdata  out  DATA_W  DM write data.
- mem_rdata  in  DATA_W  DM read data; valid MEM_LAT cycles after the address is issued.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE.
  - ack, rdata, mem_addr, mem_we, mem_wdata, busy all = 0; grant_id = 0.
  - last_grant = NUM_CORES-1, so core 0 wins the first arbitration.
  - Mask flag cleared; wait counter = 0.
- Reset mid-transaction:
  - The in-flight access is abandoned, no ack is issued, mem_we drops at once.
  - The requester must keep req high, so it is re-arbitrated after reset release.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If any eligible req bit is set, choose the winner round-robin, searching from (last_grant+1) mod NUM_CORES upward with wrap.
  - Latch the winner's id, we, addr and wdata; set grant_id; go to ISSUE.
  - Otherwise stay in IDLE.
- Eligibility mask:
  - In the first IDLE cycle after DONE, the core just served is ineligible. This covers the cycle in which that core drops req in response to ack.
  - The mask clears after that one cycle.
  - If the masked core is the only requester, it is served one cycle later.
- ISSUE (one cycle):
  - mem_addr and mem_wdata = latched values; mem_we = latched we.
  - Write: go to DONE.
  - Read: load wait counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - mem_we = 0; mem_addr held.
  - When the counter is 0, capture mem_rdata into rdata and go to DONE. Otherwise decrement.
  - Total WAIT length is MEM_LAT cycles.
- DONE (one cycle):
  - ack[grant_id] = 1, all other ack bits 0.
  - last_grant = grant_id; set mask; go to IDLE.
- Latency, counted from the IDLE cycle where the winner is chosen (cycle 0):
  - Write: mem_we high in cycle 1, ack in cycle 2.
  - Read: ack in cycle MEM_LAT+2.
- Throughput: one access per 3 cycles for writes and MEM_LAT+3 cycles for reads, including the IDLE cycle.
- Changes to req, we, addr or wdata after selection are ignored until that core's ack.
- A requester dropping req before ack is a protocol error. The transaction still completes and the ack is still issued.
- Round-robin guarantee: every continuously requesting core is served within NUM_CORES grants.
- rdata is not modified by writes.

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority (lowest eligible index wins); last_grant still drives the one-cycle mask. Cores 0 and 1 requesting continuously alternate 0,1,0,1; higher-indexed cores can starve.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: hold rst_n=0 with all req=1 -> ack=0, mem_we=0, busy=0, grant_id=0. After release, the first grant goes to core 0.
- Single write: core 2 writes addr 0x10, wdata 0xABCD -> cycle 1 has mem_we=1, mem_addr=0x10, mem_wdata=0xABCD for exactly one cycle; cycle 2 has ack=4'b0100.
- Single read, MEM_LAT=1: core 1 reads 0x10 with the DM model returning 0xABCD -> ack=4'b0010 in cycle 3 with rdata=0xABCD; mem_we stays 0 throughout.
- Contention: all 4 cores issue back-to-back reads -> grant order 0,1,2,3,0,1 with one ack per transaction and no overlap. With DM_ARB_FIXED_PRIO_EN defined -> order 0,1,0,1 and cores 2/3 never acked.
- Reset during WAIT (MEM_LAT=3): assert rst_n=0 in the second WAIT cycle -> mem_we and ack remain 0, no rdata update. After release, core 0 is served first.
- Latency sweep with MEM_LAT=3: a single read -> ack exactly 5 cycles after arbitration; a write -> ack 2 cycles after arbitration.
